// File: rtl/kpd_pkg.sv
// kpd_pkg: shared constants for the keypad entry controller.
//   - Key codes delivered by the keypad decoder (enter, backspace, none).
//   - FSM state encoding (2 bits) for kpd_entry_ctrl.
//   - BCD digit width and a small digit-classification helper.
// No ports; imported by kpd_entry_ctrl_if, kpd_digit_buf and kpd_entry_ctrl.
package kpd_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [3:0] KEY_ENTER = 4'ha;
    localparam logic [3:0] KEY_BACK  = 4'hb;
    localparam logic [3:0] KEY_NONE  = 4'hf;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/kpd_entry_ctrl_if.sv
// kpd_entry_ctrl_if: valid/ready handshake carrying one completed keypad entry.
//   data  : BCD digits, last-typed digit in [3:0], unused upper digits zero
//   count : number of digits in data
//   valid : entry available, held until accepted
//   ready : consumer accepts when valid & ready
// Modports: master (entry controller side), slave (consumer side).
interface kpd_entry_ctrl_if
    import kpd_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned CNT_W    = 3
) ();

    logic [DIGIT_W*N_DIGITS-1:0] data;
    logic [CNT_W-1:0]            count;
    logic                        valid;
    logic                        ready;

    modport master (
        output data,
        output count,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  count,
        input  valid,
        output ready
    );

endinterface

// File: rtl/kpd_digit_buf.sv
// kpd_digit_buf: N_DIGITS-deep BCD shift buffer.
//   clk, rst : clock, synchronous active-high reset
//   clear    : empty the buffer (highest priority)
//   push     : shift digit in at [3:0]; ignored when full
//   pop      : drop the digit at [3:0]; ignored when empty
//   digit    : BCD digit to push
//   digits   : buffer contents, last pushed digit in [3:0], unused upper digits zero
//   count    : number of digits held
//   full     : count == N_DIGITS
module kpd_digit_buf
    import kpd_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DIGIT_W-1:0]          digit,
    output logic [DIGIT_W*N_DIGITS-1:0] digits,
    output logic [CNT_W-1:0]            count,
    output logic                        full
);

    localparam int unsigned    BUF_W    = DIGIT_W * N_DIGITS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_DIGITS);

    logic [BUF_W-1:0] digits_q;
    logic [CNT_W-1:0] count_q;
    logic             empty;

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
    end

    // Guards make the count saturate at both ends whatever the caller does.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            digits_q <= '0;
            count_q  <= '0;
        end else if (push && !full) begin
            digits_q <= (digits_q << DIGIT_W) | BUF_W'(digit);
            count_q  <= count_q + 1'b1;
        end else if (pop && !empty) begin
            digits_q <= digits_q >> DIGIT_W;
            count_q  <= count_q - 1'b1;
        end
    end

    assign digits = digits_q;
    assign count  = count_q;

endmodule

// File: rtl/kpd_entry_ctrl.sv
// kpd_entry_ctrl: turns debounced keypad strobes into multi-digit BCD entries.
//   CLK_50M     : system clock
//   RST         : synchronous reset, active-high
//   KPD_down    : one-cycle key-press strobe
//   KPD_up      : one-cycle key-release strobe (re-arms key acceptance)
//   KPD_value   : 0-9 digit, 4'ha enter, 4'hb backspace, 4'hf none
//   entry       : completed-entry handshake (kpd_entry_ctrl_if.master)
//   DISP_digits : live buffer contents, same packing as entry.data
//   DISP_count  : live digit count
//   ERR_full    : one-cycle pulse, digit rejected because buffer is full
//   TIMEOUT     : one-cycle pulse, entry aborted after TIMEOUT_CYC idle cycles
// Optional feature macro: KPD_TIMEOUT_EN enables the idle timeout; without it
// TIMEOUT is tied to 0 and no timeout counter exists.
module kpd_entry_ctrl
    import kpd_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned TIMEOUT_CYC = 250000000,
    parameter int unsigned TO_W        = 28
) (
    input  logic                        CLK_50M,
    input  logic                        RST,
    input  logic                        KPD_down,
    input  logic                        KPD_up,
    input  logic [3:0]                  KPD_value,
    kpd_entry_ctrl_if.master            entry,
    output logic [DIGIT_W*N_DIGITS-1:0] DISP_digits,
    output logic [CNT_W-1:0]            DISP_count,
    output logic                        ERR_full,
    output logic                        TIMEOUT
);

    localparam int unsigned BUF_W = DIGIT_W * N_DIGITS;

    if ((N_DIGITS < 1) || (N_DIGITS > 8)) begin : g_bad_n_digits
        $error("N_DIGITS must be 1..8");
    end
    if ((64'd1 << CNT_W) <= 64'(N_DIGITS)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for N_DIGITS");
    end
    if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT_CYC");
    end

    logic [1:0]       state_q, state_d;
    logic             armed_q;
    logic             accept;
    logic             key_digit, key_back, key_enter;
    logic             xfer;
    logic             timeout_hit;
    logic             buf_push, buf_pop, buf_clear, buf_full;
    logic [BUF_W-1:0] buf_digits;
    logic [CNT_W-1:0] buf_count;
    logic             err_q;
    logic             valid_q;
    logic [BUF_W-1:0] data_q;
    logic [CNT_W-1:0] count_q;

    // Keys are only taken once per press (armed) and never while an entry waits in HOLD.
    always_comb begin
        accept    = KPD_down && armed_q && (KPD_value != KEY_NONE)
                    && ((state_q == ST_IDLE) || (state_q == ST_ENTRY));
        key_digit = accept && is_digit(KPD_value);
        key_back  = accept && (KPD_value == KEY_BACK);
        key_enter = accept && (KPD_value == KEY_ENTER);
        xfer      = valid_q && entry.ready;
    end

    always_comb begin
        buf_push  = key_digit && !buf_full;
        buf_pop   = key_back && (state_q == ST_ENTRY);
        buf_clear = ((state_q == ST_HOLD) && xfer) || timeout_hit;
    end

    kpd_digit_buf #(
        .N_DIGITS (N_DIGITS),
        .CNT_W    (CNT_W)
    ) u_digit_buf (
        .clk    (CLK_50M),
        .rst    (RST),
        .clear  (buf_clear),
        .push   (buf_push),
        .pop    (buf_pop),
        .digit  (KPD_value),
        .digits (buf_digits),
        .count  (buf_count),
        .full   (buf_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_digit) state_d = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (key_enter) begin
                    state_d = ST_HOLD;
                end else if (key_back && (buf_count == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (xfer) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= key_digit && buf_full;
            if (KPD_up) begin
                armed_q <= 1'b1;
            end else if (accept) begin
                armed_q <= 1'b0;
            end
        end
    end

    // Entry registers are only loaded on enter, so they stay stable through HOLD.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else if (key_enter && (state_q == ST_ENTRY)) begin
            valid_q <= 1'b1;
            data_q  <= buf_digits;
            count_q <= buf_count;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

`ifdef KPD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    // Counter sits at 0 outside ENTRY and restarts on every accepted key.
    assign timeout_hit = (state_q == ST_ENTRY) && !accept
                         && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK_50M) begin
        if (RST || (state_q != ST_ENTRY) || accept || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign TIMEOUT     = 1'b0;
`endif

    assign entry.valid = valid_q;
    assign entry.data  = data_q;
    assign entry.count = count_q;
    assign DISP_digits = buf_digits;
    assign DISP_count  = buf_count;
    assign ERR_full    = err_q;

endmodule

// File: tb/tb_kpd_entry_ctrl.sv
// tb_kpd_entry_ctrl: directed stimulus for kpd_entry_ctrl with a queue-based
// reference model checked every cycle, plus hand-computed literal checks.
// Build with or without KPD_TIMEOUT_EN; TIMEOUT_CYC is set to 100 here.
module tb_kpd_entry_ctrl;
    import kpd_pkg::*;

    localparam int unsigned N      = 4;
    localparam int unsigned CW     = 3;
    localparam int unsigned TO_CYC = 100;
    localparam int unsigned TOW    = 8;
`ifdef KPD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          down  = 1'b0;
    logic          up    = 1'b0;
    logic [3:0]    value = 4'hf;
    logic [4*N-1:0] disp;
    logic [CW-1:0]  dcount;
    logic           err;
    logic           tout;

    kpd_entry_ctrl_if #(.N_DIGITS(N), .CNT_W(CW)) eif ();

    kpd_entry_ctrl #(
        .N_DIGITS    (N),
        .CNT_W       (CW),
        .TIMEOUT_CYC (TO_CYC),
        .TO_W        (TOW)
    ) dut (
        .CLK_50M     (clk),
        .RST         (rst),
        .KPD_down    (down),
        .KPD_up      (up),
        .KPD_value   (value),
        .entry       (eif.master),
        .DISP_digits (disp),
        .DISP_count  (dcount),
        .ERR_full    (err),
        .TIMEOUT     (tout)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model: digits kept oldest-first in a queue.
    int             q[$];
    bit             m_valid = 1'b0;
    logic [4*N-1:0] m_data  = '0;
    int             m_count = 0;
    bit             m_armed = 1'b1;
    bit             m_err   = 1'b0;
    bit             m_to    = 1'b0;
    int             idle_cnt = 0;
    bit             started = 1'b0;

    function automatic logic [4*N-1:0] pack();
        logic [4*N-1:0] r = '0;
        foreach (q[i]) r = (r << 4) | (4*N)'(q[i]);
        return r;
    endfunction

    task automatic model_step();
        bit acc = 1'b0;
        started = 1'b1;
        if (rst) begin
            q.delete();
            m_valid = 1'b0; m_data = '0; m_count = 0; m_armed = 1'b1;
            m_err = 1'b0; m_to = 1'b0; idle_cnt = 0;
            return;
        end
        m_err = 1'b0;
        m_to  = 1'b0;
        if (m_valid) begin
            if (eif.ready) begin
                m_valid = 1'b0;
                q.delete();
            end
        end else if (down && m_armed && value != 4'hf) begin
            acc = 1'b1;
            idle_cnt = 0;
            if (value <= 4'd9) begin
                if (q.size() < N) q.push_back(int'(value));
                else m_err = 1'b1;
            end else if (value == 4'hb) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (value == 4'ha && q.size() > 0) begin
                m_valid = 1'b1;
                m_data  = pack();
                m_count = q.size();
            end
        end else if (q.size() > 0 && TO_EN) begin
            idle_cnt++;
            if (idle_cnt == TO_CYC) begin
                q.delete();
                m_to = 1'b1;
                idle_cnt = 0;
            end
        end
        if (up) m_armed = 1'b1;
        else if (acc) m_armed = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    int             valid_cycles = 0;
    int             err_seen = 0;
    int             to_seen = 0;
    logic [4*N-1:0] last_data = '0;
    logic [CW-1:0]  last_count = '0;

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("disp_digits", disp, pack());
            check("disp_count", dcount, q.size());
            check("entry_valid", eif.valid, m_valid);
            check("err_full", err, m_err);
            check("timeout", tout, m_to);
            if (m_valid) begin
                check("entry_data", eif.data, m_data);
                check("entry_count", eif.count, m_count);
            end
        end
        if (eif.valid === 1'b1) begin
            valid_cycles++;
            last_data  = eif.data;
            last_count = eif.count;
        end
        if (err === 1'b1) err_seen++;
        if (tout === 1'b1) to_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] v);
        down = 1'b1; value = v; tick();
        down = 1'b0; value = 4'hf; tick();
        up = 1'b1; tick();
        up = 1'b0; tick();
    endtask

    int v0, e0, t0;

    initial begin
        eif.ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_disp", disp, 0);
        check("rst_dcount", dcount, 0);
        check("rst_valid", eif.valid, 0);
        check("rst_err", err, 0);
        check("rst_timeout", tout, 0);

        // 1,2,3,enter with ready high
        key(4'd1); key(4'd2); key(4'd3);
        check("t1_disp", disp, 32'h0123);
        check("t1_dcount", dcount, 3);
        v0 = valid_cycles;
        key(4'ha);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_data", last_data, 32'h0123);
        check("t1_count", last_count, 3);
        check("t1_dcount_after", dcount, 0);

        // overflow, backspace, retype
        e0 = err_seen;
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("t2_disp_full", disp, 32'h1234);
        check("t2_err_pulses", err_seen - e0, 1);
        key(4'hb);
        check("t2_disp_back", disp, 32'h0123);
        key(4'd9); key(4'ha);
        check("t2_data", last_data, 32'h1239);
        check("t2_count", last_count, 4);

        // consumer stalls; keys during HOLD ignored
        eif.ready = 1'b0;
        key(4'd7); key(4'ha); key(4'd4); key(4'd5);
        repeat (12) tick();
        check("t3_valid_held", eif.valid, 1);
        check("t3_data", eif.data, 32'h0007);
        check("t3_count", eif.count, 1);
        check("t3_disp", disp, 32'h0007);
        eif.ready = 1'b1;
        tick();
        check("t3_valid_drop", eif.valid, 0);
        check("t3_disp_clear", disp, 0);
        check("t3_dcount_clear", dcount, 0);

        // two presses with no release between
        down = 1'b1; value = 4'd3; tick();
        down = 1'b0; value = 4'hf; tick();
        down = 1'b1; value = 4'd3; tick();
        down = 1'b0; value = 4'hf; tick();
        check("t4_dcount", dcount, 1);
        check("t4_disp", disp, 32'h0003);
        up = 1'b1; tick(); up = 1'b0; tick();
        key(4'hb);
        check("t4_back_idle", dcount, 0);

        // none key and enter/back in IDLE do nothing; none leaves armed set
        key(4'hb); key(4'ha);
        check("t5_dcount", dcount, 0);
        check("t5_valid", eif.valid, 0);
        down = 1'b1; value = 4'hf; tick();
        down = 1'b0; tick();
        down = 1'b1; value = 4'd6; tick();
        down = 1'b0; value = 4'hf; tick();
        check("t5_armed_kept", disp, 32'h0006);
        up = 1'b1; tick(); up = 1'b0; tick();
        key(4'hb);

        // idle timeout
        t0 = to_seen;
        key(4'd8);
        repeat (110) tick();
`ifdef KPD_TIMEOUT_EN
        check("t6_timeout_pulses", to_seen - t0, 1);
        check("t6_dcount", dcount, 0);
`else
        check("t6_no_timeout", to_seen - t0, 0);
        check("t6_dcount_kept", dcount, 1);
        key(4'hb);
`endif

        // reset during HOLD
        eif.ready = 1'b0;
        key(4'd2); key(4'ha);
        check("t7_hold_valid", eif.valid, 1);
        rst = 1'b1;
        tick();
        check("t7_valid", eif.valid, 0);
        check("t7_data", eif.data, 0);
        check("t7_count", eif.count, 0);
        check("t7_disp", disp, 0);
        check("t7_dcount", dcount, 0);
        rst = 1'b0;
        eif.ready = 1'b1;
        tick();
        key(4'd5); key(4'ha);
        check("t7_post_data", last_data, 32'h0005);
        check("t7_post_count", last_count, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
